// File: rtl/servo_pulse_capture_if.sv
// Signal bundle between a servo PWM source/monitor and servo_pulse_capture.
// The capture block sits on the slave side: it takes the PWM line and drives the results.
interface servo_pulse_capture_if;
   logic        pwm_in;
   logic        sample_valid;
   logic [20:0] pulse_width;
   logic [20:0] period;
   logic [20:0] position;
   logic        in_range;
   logic        signal_lost;

   modport master (
      output pwm_in,
      input  sample_valid, pulse_width, period, position, in_range, signal_lost
   );

   modport slave (
      input  pwm_in,
      output sample_valid, pulse_width, period, position, in_range, signal_lost
   );
endinterface

// File: rtl/servo_pulse_capture.sv
// Servo PWM receiver: measures high time and period of pwm_in and strobes each complete pulse
// with a range check and a signed offset from center; flags loss of signal on timeout.
module servo_pulse_capture #(
   parameter int unsigned MIN_PULSE    = 25_000,
   parameter int unsigned MAX_PULSE    = 125_000,
   parameter int unsigned CENTER_PULSE = 75_000,
   parameter int unsigned TIMEOUT      = 2_000_000
) (
   input  logic                 clk,
   input  logic                 rst,
   servo_pulse_capture_if.slave bus
);
   localparam logic [20:0] MIN_C = 21'(MIN_PULSE);
   localparam logic [20:0] MAX_C = 21'(MAX_PULSE);
   localparam logic [20:0] CTR_C = 21'(CENTER_PULSE);
   localparam logic [20:0] TMO_C = 21'(TIMEOUT);

   typedef enum logic [1:0] {SEEK, ARM, HIGH, LOW} state_e;

   state_e      state_q;
   logic        s1_q, s2_q, sp_q;
   logic [1:0]  flush_q;
   logic [20:0] hi_cnt_q, per_cnt_q, width_q;
   logic [20:0] hi_cnt_d, per_cnt_d;
   logic        sample_valid_q, in_range_q, signal_lost_q;
   logic [20:0] pulse_width_q, period_q, position_q;
   logic        rise, fall, tmo;

   always_comb begin
      rise      = s2_q & ~sp_q;
      fall      = ~s2_q & sp_q;
      tmo       = (per_cnt_q == TMO_C) & ~rise;
      per_cnt_d = (per_cnt_q == TMO_C) ? per_cnt_q : per_cnt_q + 21'd1;
      hi_cnt_d  = (s2_q && (hi_cnt_q != TMO_C)) ? hi_cnt_q + 21'd1 : hi_cnt_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q           <= 1'b0;
         s2_q           <= 1'b0;
         sp_q           <= 1'b0;
         flush_q        <= '0;
         state_q        <= SEEK;
         hi_cnt_q       <= '0;
         per_cnt_q      <= '0;
         width_q        <= '0;
         sample_valid_q <= 1'b0;
         pulse_width_q  <= '0;
         period_q       <= '0;
         position_q     <= '0;
         in_range_q     <= 1'b0;
         signal_lost_q  <= 1'b1;
      end else begin
         s1_q           <= bus.pwm_in;
         s2_q           <= s1_q;
         sp_q           <= s2_q;
         flush_q        <= {flush_q[0], 1'b1};
         sample_valid_q <= 1'b0;
         unique case (state_q)
            // The synchronizer holds reset zeros for two cycles; judging s2 before it has
            // refilled would mistake a pulse already in progress at reset release for a low level.
            SEEK: if (flush_q[1] && !s2_q) state_q <= ARM;
            ARM: begin
               if (rise) begin
                  hi_cnt_q  <= 21'd1;
                  per_cnt_q <= 21'd1;
                  state_q   <= HIGH;
               end
            end
            HIGH: begin
               if (tmo) begin
                  signal_lost_q <= 1'b1;
                  state_q       <= SEEK;
               end else begin
                  per_cnt_q <= per_cnt_d;
                  hi_cnt_q  <= hi_cnt_d;
                  if (fall) begin
                     width_q <= hi_cnt_q;
                     state_q <= LOW;
                  end
               end
            end
            LOW: begin
               if (rise) begin
                  pulse_width_q  <= width_q;
                  period_q       <= per_cnt_q;
                  position_q     <= width_q - CTR_C;
                  in_range_q     <= (width_q >= MIN_C) && (width_q <= MAX_C);
                  sample_valid_q <= 1'b1;
                  signal_lost_q  <= 1'b0;
                  hi_cnt_q       <= 21'd1;
                  per_cnt_q      <= 21'd1;
                  state_q        <= HIGH;
               end else if (tmo) begin
                  signal_lost_q <= 1'b1;
                  state_q       <= SEEK;
               end else begin
                  per_cnt_q <= per_cnt_d;
               end
            end
         endcase
      end
   end

   always_comb begin
      bus.sample_valid = sample_valid_q;
      bus.pulse_width  = pulse_width_q;
      bus.period       = period_q;
      bus.position     = position_q;
      bus.in_range     = in_range_q;
      bus.signal_lost  = signal_lost_q;
   end
endmodule

// File: tb/tb_servo_pulse_capture.sv
// Directed bench for servo_pulse_capture with a scaled-down timebase; expected samples are
// queued when a rising edge is driven and matched against each strobe, including its cycle.
module tb_servo_pulse_capture;
   localparam int unsigned MIN_P = 25;
   localparam int unsigned MAX_P = 125;
   localparam int unsigned CTR_P = 75;
   localparam int unsigned TMO   = 2000;

   typedef struct {
      logic [20:0] w;
      logic [20:0] p;
      logic [20:0] pos;
      logic        rng;
      int          cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   servo_pulse_capture_if bus ();

   servo_pulse_capture #(
      .MIN_PULSE   (MIN_P),
      .MAX_PULSE   (MAX_P),
      .CENTER_PULSE(CTR_P),
      .TIMEOUT     (TMO)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int   cyc = 0;
   int   total = 0;
   int   bad = 0;
   exp_t sb[$];
   exp_t last;
   exp_t mon_e;
   bit   mon_exp;
   bit   armed = 1'b0;
   int   last_h = 0;
   int   last_p = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t mk(input int h, input int p, input int c);
      exp_t e;
      e.w   = 21'(h);
      e.p   = 21'(p);
      e.pos = 21'(h - int'(CTR_P));
      e.rng = (h >= int'(MIN_P)) && (h <= int'(MAX_P));
      e.cyc = c;
      return e;
   endfunction

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Any rise while the block is tracking reports the previously driven pulse 3 clocks later.
   task automatic rise_now();
      bus.pwm_in = 1'b1;
      if (armed) sb.push_back(mk(last_h, last_p, cyc + 3));
   endtask

   task automatic pulse(input int h, input int p);
      rise_now();
      armed  = 1'b1;
      last_h = h;
      last_p = p;
      tick(h);
      bus.pwm_in = 1'b0;
      tick(p - h);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_sv"},   32'(bus.sample_valid), 32'd0);
      check({tag, "_pw"},   32'(bus.pulse_width),  32'd0);
      check({tag, "_per"},  32'(bus.period),       32'd0);
      check({tag, "_pos"},  32'(bus.position),     32'd0);
      check({tag, "_rng"},  32'(bus.in_range),     32'd0);
      check({tag, "_lost"}, 32'(bus.signal_lost),  32'd1);
   endtask

   task automatic check_hold(input string tag);
      check({tag, "_pw"},  32'(bus.pulse_width), 32'(last.w));
      check({tag, "_per"}, 32'(bus.period),      32'(last.p));
      check({tag, "_pos"}, 32'(bus.position),    32'(last.pos));
      check({tag, "_rng"}, 32'(bus.in_range),    32'(last.rng));
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         mon_exp = (sb.size() != 0) && (sb[0].cyc == cyc);
         if (mon_exp || bus.sample_valid) begin
            check("strobe", 32'(bus.sample_valid), 32'(mon_exp));
            if (mon_exp) begin
               mon_e = sb.pop_front();
               check("s_width",  32'(bus.pulse_width), 32'(mon_e.w));
               check("s_period", 32'(bus.period),      32'(mon_e.p));
               check("s_pos",    32'(bus.position),    32'(mon_e.pos));
               check("s_rng",    32'(bus.in_range),    32'(mon_e.rng));
               check("s_lost",   32'(bus.signal_lost), 32'd0);
               last = mon_e;
            end
         end
      end
   end

   initial begin
      int r;
      last = '{w: '0, p: '0, pos: '0, rng: 1'b0, cyc: 0};
      bus.pwm_in = 1'b0;
      rst = 1'b1;
      tick(3);
      check_reset_vals("rst0");
      rst = 1'b0;
      tick(10);

      // Nominal centered pulses; first rise only arms.
      pulse(75, 1000);
      check("lost_before_first", 32'(bus.signal_lost), 32'd1);
      repeat (3) pulse(75, 1000);
      check("lost_after_first", 32'(bus.signal_lost), 32'd0);
      check("nominal_pw", 32'(bus.pulse_width), 32'd75);

      // Range limits and an out-of-range short pulse.
      pulse(25, 1000);
      pulse(125, 1000);
      pulse(20, 1000);
      pulse(75, 1000);
      check("short_pw",  32'(bus.pulse_width), 32'd20);
      check("short_pos", 32'(bus.position),    32'h1FFFC9);
      check("short_rng", 32'(bus.in_range),    32'd0);

      // Stuck high: lost exactly TMO clocks after the strobe of the stuck pulse's rise.
      r = cyc;
      rise_now();
      armed = 1'b0;
      tick(3 + int'(TMO) - 1);
      check("stuck_pre_lost", 32'(bus.signal_lost), 32'd0);
      tick(1);
      check("stuck_lost", 32'(bus.signal_lost), 32'd1);
      check("stuck_cyc", 32'(cyc - r), 32'(3 + int'(TMO)));
      check_hold("stuck_hold");
      tick(50);
      bus.pwm_in = 1'b0;
      tick(20);
      pulse(75, 1000);
      check("recov_still_lost", 32'(bus.signal_lost), 32'd1);
      pulse(75, 1000);
      pulse(75, 1000);
      check("recov_lost", 32'(bus.signal_lost), 32'd0);

      // Reset released while pwm_in is high mid-pulse.
      rise_now();
      tick(5);
      rst = 1'b1;
      tick(3);
      rst = 1'b0;
      armed = 1'b0;
      last = '{w: '0, p: '0, pos: '0, rng: 1'b0, cyc: 0};
      check_reset_vals("rst_hi");
      tick(40);
      bus.pwm_in = 1'b0;
      tick(200);
      repeat (3) pulse(75, 1000);
      check("rst_hi_pw", 32'(bus.pulse_width), 32'd75);

      // One-cycle reset during the LOW phase.
      rise_now();
      tick(75);
      bus.pwm_in = 1'b0;
      tick(400);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      armed = 1'b0;
      last = '{w: '0, p: '0, pos: '0, rng: 1'b0, cyc: 0};
      check_reset_vals("rst_low");
      tick(525);
      pulse(75, 1000);
      check("rst_low_no_strobe_pw", 32'(bus.pulse_width), 32'd0);
      pulse(75, 1000);
      pulse(75, 1000);
      check("rst_low_pw", 32'(bus.pulse_width), 32'd75);

      // Period equal to TIMEOUT: edge wins over timeout.
      repeat (4) pulse(75, int'(TMO));
      check("edge_tmo_per",  32'(bus.period),      32'(TMO));
      check("edge_tmo_lost", 32'(bus.signal_lost), 32'd0);

      // One cycle longer than TIMEOUT: times out from LOW, no strobe, re-arms.
      pulse(75, int'(TMO) + 1);
      armed = 1'b0;
      tick(4);
      check("over_tmo_lost", 32'(bus.signal_lost), 32'd1);
      check("over_tmo_per",  32'(bus.period),      32'(TMO));
      pulse(75, 1000);
      pulse(75, 1000);
      tick(10);
      check("over_tmo_recov", 32'(bus.signal_lost), 32'd0);

      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
